// File: rtl/scounter_pkg.sv
// Shared types and constants for the stopwatch core.
package scounter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_e;

    localparam logic [7:0] MS10_MAX = 8'd99;
    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd99;

    // True when the time registers hold the largest displayable value 99:59:99.
    function automatic logic at_max(input logic [7:0] min_v,
                                    input logic [7:0] sec_v,
                                    input logic [7:0] ms10_v);
        return (min_v == MIN_MAX) && (sec_v == SEC_MAX) && (ms10_v == MS10_MAX);
    endfunction

endpackage

// File: rtl/scounter_tick_gen.sv
// Prescaler: counts clk_core cycles while adv is high and flags the wrap
// from CLK_DIV-1 back to 0 as a 10 ms tick.
module tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_core,
    input  logic rst,
    input  logic adv,
    input  logic zero,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The tick is only meaningful on a cycle where the prescaler actually advances.
    assign tick = adv && (cnt_q == LAST);

    // Next prescaler value: clear has priority, otherwise advance and wrap, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (zero) begin
            cnt_d = '0;
        end else if (adv) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scounter_core.sv
// Stopwatch core: run/pause/overflow control, centisecond time keeping
// with carries into seconds and minutes, and a lap capture register.
module scounter_core
    import scounter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       lap,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic [7:0] lap_min_o,
    output logic [7:0] lap_sec_o,
    output logic [7:0] lap_ms_10_o,
    output logic       lap_valid,
    output logic       running,
    output logic       overflow
);

    state_e     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] ms_10_q, ms_10_d;
    logic [7:0] lap_min_q, lap_min_d;
    logic [7:0] lap_sec_q, lap_sec_d;
    logic [7:0] lap_ms_10_q, lap_ms_10_d;
    logic       lap_valid_q, lap_valid_d;
    logic       running_q, running_d;
    logic       overflow_q, overflow_d;
    logic       adv_s;
    logic       tick_s;

    // The prescaler only moves while running and globally enabled.
    assign adv_s = (state_q == ST_RUN) && en;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_core (clk_core),
        .rst      (rst),
        .adv      (adv_s),
        .zero     (clr),
        .tick     (tick_s)
    );

    // Next-state, time increment and lap capture; clr overrides every other command.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        ms_10_d     = ms_10_q;
        lap_min_d   = lap_min_q;
        lap_sec_d   = lap_sec_q;
        lap_ms_10_d = lap_ms_10_q;
        lap_valid_d = 1'b0;
        overflow_d  = overflow_q;

        if (clr) begin
            state_d     = ST_IDLE;
            min_d       = 8'd0;
            sec_d       = 8'd0;
            ms_10_d     = 8'd0;
            lap_min_d   = 8'd0;
            lap_sec_d   = 8'd0;
            lap_ms_10_d = 8'd0;
            overflow_d  = 1'b0;
        end else begin
            // Lap copies the pre-increment time, so it reads the registers directly.
            if (lap && (state_q != ST_IDLE)) begin
                lap_min_d   = min_q;
                lap_sec_d   = sec_q;
                lap_ms_10_d = ms_10_q;
                lap_valid_d = 1'b1;
            end else begin
                lap_valid_d = 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s && at_max(min_q, sec_q, ms_10_q)) begin
                        // Saturate: hold 99:59:99 and latch the overflow flag.
                        overflow_d = 1'b1;
                        state_d    = ST_OVF;
                    end else begin
                        if (tick_s) begin
                            if (ms_10_q == MS10_MAX) begin
                                ms_10_d = 8'd0;
                                if (sec_q == SEC_MAX) begin
                                    sec_d = 8'd0;
                                    min_d = min_q + 8'd1;
                                end else begin
                                    sec_d = sec_q + 8'd1;
                                end
                            end else begin
                                ms_10_d = ms_10_q + 8'd1;
                            end
                        end else begin
                            ms_10_d = ms_10_q;
                        end
                        // A stop on a tick cycle still lets that tick count.
                        if (stop) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!stop && start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_OVF: begin
                    state_d = ST_OVF;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State, time, lap and flag registers with synchronous reset.
    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            ms_10_q     <= 8'd0;
            lap_min_q   <= 8'd0;
            lap_sec_q   <= 8'd0;
            lap_ms_10_q <= 8'd0;
            lap_valid_q <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            ms_10_q     <= ms_10_d;
            lap_min_q   <= lap_min_d;
            lap_sec_q   <= lap_sec_d;
            lap_ms_10_q <= lap_ms_10_d;
            lap_valid_q <= lap_valid_d;
            running_q   <= running_d;
            overflow_q  <= overflow_d;
        end
    end

    assign min_o       = min_q;
    assign sec_o       = sec_q;
    assign ms_10_o     = ms_10_q;
    assign lap_min_o   = lap_min_q;
    assign lap_sec_o   = lap_sec_q;
    assign lap_ms_10_o = lap_ms_10_q;
    assign lap_valid   = lap_valid_q;
    assign running     = running_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_scounter_core.sv
// Self-checking bench for scounter_core: directed scenarios plus random
// commands, all compared against a centisecond-count reference model.
module tb_scounter_core;

    localparam int CLK_DIV = 4;
    localparam int MAX_CS  = 99 * 6000 + 59 * 100 + 99;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVF   = 3;

    logic       clk = 1'b0;
    logic       rst, en, start, stop, clr, lap;
    logic [7:0] min_o, sec_o, ms_10_o, lap_min_o, lap_sec_o, lap_ms_10_o;
    logic       lap_valid, running, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: elapsed time as one integer of centiseconds.
    int m_cs     = 0;
    int m_lap_cs = 0;
    int m_phase  = 0;
    int m_mode   = M_IDLE;
    bit m_lapv   = 1'b0;
    bit m_ovf    = 1'b0;

    scounter_core #(.CLK_DIV(CLK_DIV)) dut (
        .clk_core    (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .stop        (stop),
        .clr         (clr),
        .lap         (lap),
        .min_o       (min_o),
        .sec_o       (sec_o),
        .ms_10_o     (ms_10_o),
        .lap_min_o   (lap_min_o),
        .lap_sec_o   (lap_sec_o),
        .lap_ms_10_o (lap_ms_10_o),
        .lap_valid   (lap_valid),
        .running     (running),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    wire [50:0] dut_vec = {min_o, sec_o, ms_10_o, lap_min_o, lap_sec_o, lap_ms_10_o,
                           lap_valid, running, overflow};

    function automatic logic [50:0] exp_vec();
        return {8'(m_cs / 6000), 8'((m_cs / 100) % 60), 8'(m_cs % 100),
                8'(m_lap_cs / 6000), 8'((m_lap_cs / 100) % 60), 8'(m_lap_cs % 100),
                m_lapv, (m_mode == M_RUN), m_ovf};
    endfunction

    task automatic model_step();
        bit t_tick;
        if (rst || clr) begin
            m_cs = 0; m_lap_cs = 0; m_phase = 0; m_mode = M_IDLE; m_lapv = 1'b0; m_ovf = 1'b0;
        end else begin
            m_lapv = lap && (m_mode != M_IDLE);
            if (m_lapv) m_lap_cs = m_cs;
            t_tick = (m_mode == M_RUN) && en && (m_phase == CLK_DIV - 1);
            if (m_mode == M_RUN && en) m_phase = (m_phase + 1) % CLK_DIV;
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_RUN;
                M_RUN: begin
                    if (t_tick && m_cs == MAX_CS) begin
                        m_ovf = 1'b1; m_mode = M_OVF;
                    end else begin
                        if (t_tick) m_cs = m_cs + 1;
                        if (stop) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (start && !stop) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; lap = 1'b0;
    endtask

    task automatic clear_and_start();
        idle_inputs();
        clr = 1'b1; cyc(); clr = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic run_until_cs(input int target);
        for (int i = 0; i < 4000 && m_cs != target; i++) cyc();
        n_tests++;
        if (m_cs != target || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL run_until_%0d: got %h expected %h (model cs %0d)", target, dut_vec, exp_vec(), m_cs);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; start = 1'b1; lap = 1'b1; stop = 1'(($urandom % 2));
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_tests++;
            if (dut_vec !== 51'd0) begin
                n_fail++;
                $display("FAIL reset_%0d: got %h expected 0", i, dut_vec);
            end
        end
        idle_inputs();
    endtask

    task automatic test_count();
        idle_inputs();
        start = 1'b1; cyc(); start = 1'b0;
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL count_running: got %b expected 1", running); end
        for (int k = 1; k <= 400; k++) begin
            cyc();
            if (k == 3) begin
                n_tests++;
                if (ms_10_o !== 8'd0) begin n_fail++; $display("FAIL count_ms_early: got %0d expected 0", ms_10_o); end
            end
            if (k == 4) begin
                n_tests++;
                if (ms_10_o !== 8'd1) begin n_fail++; $display("FAIL count_ms_first: got %0d expected 1", ms_10_o); end
            end
            if (k == 400) begin
                n_tests++;
                if (sec_o !== 8'd1 || ms_10_o !== 8'd0 || dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL count_sec: got %h expected %h", dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_pause();
        int extra;
        int held;
        clear_and_start();
        run_until_cs(50);
        extra = $urandom_range(0, 2);
        for (int i = 0; i < extra; i++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        held = m_phase;
        n_tests++;
        if (running !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL pause_enter: got %h expected %h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 100; i++) begin
            stop = 1'(($urandom % 2));
            cyc();
            n_tests++;
            if ({min_o, sec_o, ms_10_o} !== {8'd0, 8'd0, 8'd50}) begin
                n_fail++; $display("FAIL pause_frozen: got %0d:%0d:%0d expected 0:0:50", min_o, sec_o, ms_10_o);
            end
        end
        stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i < 4 - held; i++) cyc();
        n_tests++;
        if (ms_10_o !== 8'd50) begin n_fail++; $display("FAIL pause_resume_early: got %0d expected 50", ms_10_o); end
        cyc();
        n_tests++;
        if (ms_10_o !== 8'd51 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL pause_resume: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lap();
        clear_and_start();
        run_until_cs(123);
        lap = 1'b1; cyc(); lap = 1'b0;
        n_tests++;
        if ({lap_min_o, lap_sec_o, lap_ms_10_o, lap_valid} !== {8'd0, 8'd1, 8'd23, 1'b1}) begin
            n_fail++;
            $display("FAIL lap_capture: got %0d:%0d:%0d v=%b expected 0:1:23 v=1", lap_min_o, lap_sec_o, lap_ms_10_o, lap_valid);
        end
        cyc();
        n_tests++;
        if (lap_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL lap_single_pulse: got %h expected %h", dut_vec, exp_vec());
        end
        clr = 1'b1; cyc(); clr = 1'b0;
        lap = 1'b1; cyc(); lap = 1'b0;
        n_tests++;
        if (lap_valid !== 1'b0 || {lap_min_o, lap_sec_o, lap_ms_10_o} !== 24'd0) begin
            n_fail++; $display("FAIL lap_idle: got v=%b lap=%h expected v=0 lap=0", lap_valid, {lap_min_o, lap_sec_o, lap_ms_10_o});
        end
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        lap = 1'b1; clr = 1'b1; cyc(); lap = 1'b0; clr = 1'b0;
        cyc();
        n_tests++;
        if (lap_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL lap_with_clr: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_en();
        clear_and_start();
        for (int i = 0; i < 20 + int'($urandom_range(0, 20)); i++) cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = 1'(($urandom % 2));
            cyc();
            n_tests++;
            if (dut_vec !== exp_vec() || int'(dut.u_tick.cnt_q) != m_phase) begin
                n_fail++;
                $display("FAIL en_frozen: got %h psc %0d expected %h psc %0d", dut_vec, dut.u_tick.cnt_q, exp_vec(), m_phase);
            end
        end
        en = 1'b1; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_tests++;
            if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL en_resume: got %h expected %h", dut_vec, exp_vec()); end
        end
        clr = 1'b1; start = 1'b1; cyc(); clr = 1'b0; start = 1'b0;
        n_tests++;
        if (running !== 1'b0 || {min_o, sec_o, ms_10_o} !== 24'd0) begin
            n_fail++; $display("FAIL clr_start: got run=%b time=%h expected run=0 time=0", running, {min_o, sec_o, ms_10_o});
        end
    endtask

    task automatic test_overflow();
        clear_and_start();
        cyc(); cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        m_cs = MAX_CS - 1;
        force dut.min_q = 8'd99;
        force dut.sec_q = 8'd59;
        force dut.ms_10_q = 8'd98;
        cyc();
        release dut.min_q;
        release dut.sec_q;
        release dut.ms_10_q;
        cyc();
        n_tests++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL ovf_preload: got %h expected %h", dut_vec, exp_vec()); end
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 20 && m_mode != M_OVF; i++) cyc();
        n_tests++;
        if ({min_o, sec_o, ms_10_o, overflow, running} !== {8'd99, 8'd59, 8'd99, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_saturate: got %0d:%0d:%0d ovf=%b run=%b expected 99:59:99 ovf=1 run=0", min_o, sec_o, ms_10_o, overflow, running);
        end
        for (int i = 0; i < 100; i++) begin
            start = 1'(($urandom % 2)); stop = 1'(($urandom % 2));
            cyc();
            n_tests++;
            if ({min_o, sec_o, ms_10_o, overflow, running} !== {8'd99, 8'd59, 8'd99, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL ovf_hold: got %0d:%0d:%0d ovf=%b run=%b", min_o, sec_o, ms_10_o, overflow, running);
            end
        end
        start = 1'b0; stop = 1'b0;
        clr = 1'b1; cyc(); clr = 1'b0;
        n_tests++;
        if (dut_vec !== 51'd0) begin n_fail++; $display("FAIL ovf_clr: got %h expected 0", dut_vec); end
    endtask

    task automatic test_rst_mid_run();
        clear_and_start();
        run_until_cs(205);
        rst = 1'b1; lap = 1'b1; cyc(); rst = 1'b0; lap = 1'b0;
        n_tests++;
        if (dut_vec !== 51'd0) begin n_fail++; $display("FAIL rst_mid_run: got %h expected 0", dut_vec); end
        cyc();
        n_tests++;
        if (dut_vec !== 51'd0) begin n_fail++; $display("FAIL rst_mid_run_after: got %h expected 0", dut_vec); end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 2000; i++) begin
            en    = (($urandom % 8) != 0);
            start = (($urandom % 4) == 0);
            stop  = (($urandom % 6) == 0);
            clr   = (($urandom % 40) == 0);
            lap   = (($urandom % 5) == 0);
            rst   = (($urandom % 300) == 0);
            cyc();
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_count();
        test_pause();
        test_lap();
        test_en();
        test_overflow();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
